// File: rtl/ysyx_23060184_axi_rr_arbiter.sv
// N-master to 1-slave AXI4-lite arbiter: grants one master at a time and holds the grant
// until that transaction's response handshake, scheduling round-robin or by fixed priority.
module ysyx_23060184_axi_rr_arbiter #(
    parameter int NUM_MASTERS   = 2,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int RESP_WIDTH    = 2,
    parameter int PRIORITY_MODE = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    // master side
    input  logic [NUM_MASTERS-1:0]                m_arvalid,
    output logic [NUM_MASTERS-1:0]                m_arready,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_araddr,
    output logic [NUM_MASTERS-1:0]                m_rvalid,
    input  logic [NUM_MASTERS-1:0]                m_rready,
    output logic [DATA_WIDTH-1:0]                 m_rdata,
    output logic [RESP_WIDTH-1:0]                 m_rresp,
    input  logic [NUM_MASTERS-1:0]                m_awvalid,
    output logic [NUM_MASTERS-1:0]                m_awready,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_awaddr,
    input  logic [NUM_MASTERS-1:0]                m_wvalid,
    output logic [NUM_MASTERS-1:0]                m_wready,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_wdata,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]   m_wstrb,
    output logic [NUM_MASTERS-1:0]                m_bvalid,
    input  logic [NUM_MASTERS-1:0]                m_bready,
    output logic [RESP_WIDTH-1:0]                 m_bresp,
    // slave side
    output logic                                  s_arvalid,
    input  logic                                  s_arready,
    output logic [ADDR_WIDTH-1:0]                 s_araddr,
    input  logic                                  s_rvalid,
    output logic                                  s_rready,
    input  logic [DATA_WIDTH-1:0]                 s_rdata,
    input  logic [RESP_WIDTH-1:0]                 s_rresp,
    output logic                                  s_awvalid,
    input  logic                                  s_awready,
    output logic [ADDR_WIDTH-1:0]                 s_awaddr,
    output logic                                  s_wvalid,
    input  logic                                  s_wready,
    output logic [DATA_WIDTH-1:0]                 s_wdata,
    output logic [DATA_WIDTH/8-1:0]               s_wstrb,
    input  logic                                  s_bvalid,
    output logic                                  s_bready,
    input  logic [RESP_WIDTH-1:0]                 s_bresp,
    // status
    output logic [NUM_MASTERS-1:0]                grant,
    output logic                                  busy
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_REQ,
        ST_WR_RESP
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [NUM_MASTERS-1:0]  r_grant;
    logic [IW-1:0]           r_gidx;
    logic [IW-1:0]           r_ptr;
    logic                    r_aw_done;
    logic                    r_w_done;

    logic [NUM_MASTERS-1:0]  w_req;
    logic [NUM_MASTERS-1:0]  w_sel_onehot;
    logic [IW-1:0]           w_sel_idx;
    logic                    w_sel_found;
    logic [IW-1:0]           w_ptr_nxt;
    logic                    w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;
    logic                    w_wr_both_done;

    logic [ADDR_WIDTH-1:0]   w_araddr_arr [NUM_MASTERS];
    logic [ADDR_WIDTH-1:0]   w_awaddr_arr [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]   w_wdata_arr  [NUM_MASTERS];
    logic [SW-1:0]           w_wstrb_arr  [NUM_MASTERS];

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
        assign w_araddr_arr[gi] = m_araddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_awaddr_arr[gi] = m_awaddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata_arr[gi]  = m_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        assign w_wstrb_arr[gi]  = m_wstrb[gi*SW +: SW];
    end

    assign w_req = m_arvalid | m_awvalid;

    // Winner search: starts at the pointer in round-robin mode, at index 0 in fixed mode.
    always_comb begin
        int            j;
        logic [IW-1:0] cand;
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        w_sel_idx    = '0;
        w_sel_found  = 1'b0;
        w_sel_onehot = '0;
        j            = 0;
        cand         = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (PRIORITY_MODE != 0) begin
                j = i;
            end else begin
                j = int'(r_ptr) + i;
                if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
            end
            cand = IW'(j);
            if (!w_sel_found && w_req[cand]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = cand;
            end
        end
        w_sel_onehot[w_sel_idx] = w_sel_found;
    end

    assign w_ptr_nxt = (r_gidx == IW'(NUM_MASTERS - 1)) ? '0 : r_gidx + 1'b1;

    assign w_ar_hs        = s_arvalid & s_arready;
    assign w_r_hs         = s_rvalid  & s_rready;
    assign w_aw_hs        = s_awvalid & s_awready;
    assign w_w_hs         = s_wvalid  & s_wready;
    assign w_b_hs         = s_bvalid  & s_bready;
    assign w_wr_both_done = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_sel_found)
                            w_state_nxt = m_arvalid[w_sel_idx] ? ST_RD_ADDR : ST_WR_REQ;
            ST_RD_ADDR: if (w_ar_hs)        w_state_nxt = ST_RD_DATA;
            ST_RD_DATA: if (w_r_hs)         w_state_nxt = ST_IDLE;
            ST_WR_REQ:  if (w_wr_both_done) w_state_nxt = ST_WR_RESP;
            ST_WR_RESP: if (w_b_hs)         w_state_nxt = ST_IDLE;
            default:                        w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake routing is purely combinational through the registered grant index.
    always_comb begin
        m_arready = '0;
        m_rvalid  = '0;
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        s_araddr  = '0;
        s_awaddr  = '0;
        s_wdata   = '0;
        s_wstrb   = '0;
        if (r_state != ST_IDLE) begin
            s_araddr = w_araddr_arr[r_gidx];
            s_awaddr = w_awaddr_arr[r_gidx];
            s_wdata  = w_wdata_arr[r_gidx];
            s_wstrb  = w_wstrb_arr[r_gidx];
        end
        case (r_state)
            ST_RD_ADDR: begin
                s_arvalid         = m_arvalid[r_gidx];
                m_arready[r_gidx] = s_arready;
            end
            ST_RD_DATA: begin
                m_rvalid[r_gidx] = s_rvalid;
                s_rready         = m_rready[r_gidx];
            end
            ST_WR_REQ: begin
                s_awvalid         = m_awvalid[r_gidx] & ~r_aw_done;
                m_awready[r_gidx] = s_awready & ~r_aw_done;
                s_wvalid          = m_wvalid[r_gidx] & ~r_w_done;
                m_wready[r_gidx]  = s_wready & ~r_w_done;
            end
            ST_WR_RESP: begin
                m_bvalid[r_gidx] = s_bvalid;
                s_bready         = m_bready[r_gidx];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_gidx    <= '0;
            r_ptr     <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples the pre-edge values regardless of statement order.
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_found) begin
                        r_gidx  <= w_sel_idx;
                        r_grant <= w_sel_onehot;
                    end
                end
                ST_WR_REQ: begin
                    if (w_wr_both_done) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end else begin
                        if (w_aw_hs) r_aw_done <= 1'b1;
                        if (w_w_hs)  r_w_done  <= 1'b1;
                    end
                end
                ST_RD_DATA, ST_WR_RESP: begin
                    if (w_state_nxt == ST_IDLE) begin
                        r_grant <= '0;
                        r_ptr   <= w_ptr_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_rdata = s_rdata;
    assign m_rresp = s_rresp;
    assign m_bresp = s_bresp;
    assign grant   = r_grant;
    assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ysyx_23060184_axi_rr_arbiter.sv
// Directed bench for the AXI4-lite arbiter: a round-robin and a fixed-priority instance
// (three masters each) share all inputs; outputs are compared against hand-computed values.
module tb_ysyx_23060184_axi_rr_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int RW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
    logic [N*AW-1:0] m_araddr, m_awaddr;
    logic [N*DW-1:0] m_wdata;
    logic [N*SW-1:0] m_wstrb;
    logic            s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
    logic [DW-1:0]   s_rdata;
    logic [RW-1:0]   s_rresp, s_bresp;

    logic [N-1:0]  rr_m_arready, rr_m_rvalid, rr_m_awready, rr_m_wready, rr_m_bvalid, rr_grant;
    logic [DW-1:0] rr_m_rdata, rr_s_wdata;
    logic [RW-1:0] rr_m_rresp, rr_m_bresp;
    logic          rr_s_arvalid, rr_s_rready, rr_s_awvalid, rr_s_wvalid, rr_s_bready, rr_busy;
    logic [AW-1:0] rr_s_araddr, rr_s_awaddr;
    logic [SW-1:0] rr_s_wstrb;

    logic [N-1:0]  fp_m_arready, fp_m_rvalid, fp_m_awready, fp_m_wready, fp_m_bvalid, fp_grant;
    logic [DW-1:0] fp_m_rdata, fp_s_wdata;
    logic [RW-1:0] fp_m_rresp, fp_m_bresp;
    logic          fp_s_arvalid, fp_s_rready, fp_s_awvalid, fp_s_wvalid, fp_s_bready, fp_busy;
    logic [AW-1:0] fp_s_araddr, fp_s_awaddr;
    logic [SW-1:0] fp_s_wstrb;

    ysyx_23060184_axi_rr_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                                   .RESP_WIDTH(RW), .PRIORITY_MODE(0)) u_rr (
        .clk(clk), .rst(rst),
        .m_arvalid(m_arvalid), .m_arready(rr_m_arready), .m_araddr(m_araddr),
        .m_rvalid(rr_m_rvalid), .m_rready(m_rready), .m_rdata(rr_m_rdata), .m_rresp(rr_m_rresp),
        .m_awvalid(m_awvalid), .m_awready(rr_m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(rr_m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(rr_m_bvalid), .m_bready(m_bready), .m_bresp(rr_m_bresp),
        .s_arvalid(rr_s_arvalid), .s_arready(s_arready), .s_araddr(rr_s_araddr),
        .s_rvalid(s_rvalid), .s_rready(rr_s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_awvalid(rr_s_awvalid), .s_awready(s_awready), .s_awaddr(rr_s_awaddr),
        .s_wvalid(rr_s_wvalid), .s_wready(s_wready), .s_wdata(rr_s_wdata), .s_wstrb(rr_s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(rr_s_bready), .s_bresp(s_bresp),
        .grant(rr_grant), .busy(rr_busy)
    );

    ysyx_23060184_axi_rr_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                                   .RESP_WIDTH(RW), .PRIORITY_MODE(1)) u_fp (
        .clk(clk), .rst(rst),
        .m_arvalid(m_arvalid), .m_arready(fp_m_arready), .m_araddr(m_araddr),
        .m_rvalid(fp_m_rvalid), .m_rready(m_rready), .m_rdata(fp_m_rdata), .m_rresp(fp_m_rresp),
        .m_awvalid(m_awvalid), .m_awready(fp_m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(fp_m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(fp_m_bvalid), .m_bready(m_bready), .m_bresp(fp_m_bresp),
        .s_arvalid(fp_s_arvalid), .s_arready(s_arready), .s_araddr(fp_s_araddr),
        .s_rvalid(s_rvalid), .s_rready(fp_s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_awvalid(fp_s_awvalid), .s_awready(s_awready), .s_awaddr(fp_s_awaddr),
        .s_wvalid(fp_s_wvalid), .s_wready(s_wready), .s_wdata(fp_s_wdata), .s_wstrb(fp_s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(fp_s_bready), .s_bresp(s_bresp),
        .grant(fp_grant), .busy(fp_busy)
    );

    // Per-master request payloads.
    logic [AW-1:0] ar_addr [N] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
    logic [AW-1:0] aw_addr [N] = '{32'h9000_0000, 32'h9000_0004, 32'h9000_0008};
    logic [DW-1:0] wd      [N] = '{32'hAAAA_0000, 32'hAAAA_0001, 32'h1234_5678};
    logic [SW-1:0] ws      [N] = '{4'h1, 4'h3, 4'hF};

    typedef struct packed {
        logic [2:0] ar, aw, w, rr, br;
        logic [4:0] slv;   // {s_arready, s_rvalid, s_awready, s_wready, s_bvalid}
    } in_t;

    typedef struct packed {
        logic [2:0]  grant;
        logic        busy;
        logic [4:0]  sv;   // {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready}
        logic [2:0]  arr, rv, awr, wr, bv;
        logic [31:0] araddr, awaddr, wdata;
        logic [3:0]  wstrb;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic in_t vi(logic [2:0] ar, aw, w, rr, br, logic [4:0] slv);
        in_t v;
        v.ar = ar; v.aw = aw; v.w = w; v.rr = rr; v.br = br; v.slv = slv;
        return v;
    endfunction

    // Expected outputs; buses follow the granted master's payload, zero when idle.
    function automatic out_t vo(logic [2:0] g, logic [4:0] sv, logic [2:0] arr, rv, awr, wr, bv);
        out_t o;
        int   m;
        o = '0;
        o.grant = g; o.busy = |g; o.sv = sv;
        o.arr = arr; o.rv = rv; o.awr = awr; o.wr = wr; o.bv = bv;
        if (g != 3'b000) begin
            m = g[0] ? 0 : (g[1] ? 1 : 2);
            o.araddr = ar_addr[m]; o.awaddr = aw_addr[m]; o.wdata = wd[m]; o.wstrb = ws[m];
        end
        return o;
    endfunction

    function automatic out_t rr_out();
        out_t o;
        o.grant = rr_grant; o.busy = rr_busy;
        o.sv = {rr_s_arvalid, rr_s_rready, rr_s_awvalid, rr_s_wvalid, rr_s_bready};
        o.arr = rr_m_arready; o.rv = rr_m_rvalid; o.awr = rr_m_awready;
        o.wr = rr_m_wready; o.bv = rr_m_bvalid;
        o.araddr = rr_s_araddr; o.awaddr = rr_s_awaddr; o.wdata = rr_s_wdata; o.wstrb = rr_s_wstrb;
        return o;
    endfunction

    function automatic out_t fp_out();
        out_t o;
        o.grant = fp_grant; o.busy = fp_busy;
        o.sv = {fp_s_arvalid, fp_s_rready, fp_s_awvalid, fp_s_wvalid, fp_s_bready};
        o.arr = fp_m_arready; o.rv = fp_m_rvalid; o.awr = fp_m_awready;
        o.wr = fp_m_wready; o.bv = fp_m_bvalid;
        o.araddr = fp_s_araddr; o.awaddr = fp_s_awaddr; o.wdata = fp_s_wdata; o.wstrb = fp_s_wstrb;
        return o;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input in_t i, input out_t o);
        vec_t v;
        v.i = i; v.o = o;
        tbl.push_back(v);
    endtask

    task automatic apply(input in_t v);
        m_arvalid = v.ar; m_awvalid = v.aw; m_wvalid = v.w; m_rready = v.rr; m_bready = v.br;
        {s_arready, s_rvalid, s_awready, s_wready, s_bvalid} = v.slv;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        apply('0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        logic [2:0] exp_rr, exp_fp;
        out_t       idle_o;
        idle_o   = '0;
        m_araddr = {ar_addr[2], ar_addr[1], ar_addr[0]};
        m_awaddr = {aw_addr[2], aw_addr[1], aw_addr[0]};
        m_wdata  = {wd[2], wd[1], wd[0]};
        m_wstrb  = {ws[2], ws[1], ws[0]};
        s_rdata  = 32'hDEAD_BEEF;
        s_rresp  = '0;
        s_bresp  = '0;

        // Reset held with every master requesting and the slave fully ready.
        rst = 1'b1;
        apply(vi(3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 5'b11111));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_rr", 128'(rr_out()), 128'(idle_o));
        check("reset_fp", 128'(fp_out()), 128'(idle_o));

        // Single read from master 1, slave holds arready low for one cycle.
        add(vi(3'b010, 0, 0, 0, 0, 5'b00000), idle_o);
        add(vi(3'b010, 0, 0, 0, 0, 5'b00000), vo(3'b010, 5'b10000, 0, 0, 0, 0, 0));
        add(vi(3'b010, 0, 0, 0, 0, 5'b10000), vo(3'b010, 5'b10000, 3'b010, 0, 0, 0, 0));
        add(vi(0, 0, 0, 3'b010, 0, 5'b01000), vo(3'b010, 5'b01000, 0, 3'b010, 0, 0, 0));
        add(vi(0, 0, 0, 0, 0, 5'b00000), idle_o);
        // Split write from master 2: awready in cycle 1, wready in cycle 3, aw held after its handshake.
        add(vi(0, 3'b100, 3'b100, 0, 0, 5'b00000), idle_o);
        add(vi(0, 3'b100, 3'b100, 0, 0, 5'b00100), vo(3'b100, 5'b00110, 0, 0, 3'b100, 0, 0));
        add(vi(0, 3'b100, 3'b100, 0, 0, 5'b00000), vo(3'b100, 5'b00010, 0, 0, 0, 0, 0));
        add(vi(0, 3'b100, 3'b100, 0, 0, 5'b00010), vo(3'b100, 5'b00010, 0, 0, 0, 3'b100, 0));
        add(vi(0, 0, 0, 0, 3'b100, 5'b00000), vo(3'b100, 5'b00001, 0, 0, 0, 0, 0));
        add(vi(0, 0, 0, 0, 3'b100, 5'b00001), vo(3'b100, 5'b00001, 0, 0, 0, 0, 3'b100));
        add(vi(0, 0, 0, 0, 0, 5'b00000), idle_o);
        // Master 0 raises read and write together; read goes first, write on the next round.
        add(vi(3'b001, 3'b001, 3'b001, 3'b111, 3'b111, 5'b11111), idle_o);
        add(vi(3'b001, 3'b001, 3'b001, 3'b111, 3'b111, 5'b11111), vo(3'b001, 5'b10000, 3'b001, 0, 0, 0, 0));
        add(vi(3'b000, 3'b001, 3'b001, 3'b111, 3'b111, 5'b11111), vo(3'b001, 5'b01000, 0, 3'b001, 0, 0, 0));
        add(vi(3'b000, 3'b001, 3'b001, 3'b111, 3'b111, 5'b11111), idle_o);
        add(vi(3'b000, 3'b001, 3'b001, 3'b111, 3'b111, 5'b11111), vo(3'b001, 5'b00110, 0, 0, 3'b001, 3'b001, 0));
        add(vi(3'b000, 3'b000, 3'b000, 3'b111, 3'b111, 5'b11111), vo(3'b001, 5'b00001, 0, 0, 0, 0, 3'b001));
        add(vi(0, 0, 0, 0, 0, 5'b00000), idle_o);

        reset_dut();
        foreach (tbl[k]) begin
            apply(tbl[k].i);
            @(negedge clk);
            check($sformatf("vec%0d_rr", k), 128'(rr_out()), 128'(tbl[k].o));
            check($sformatf("vec%0d_fp", k), 128'(fp_out()), 128'(tbl[k].o));
            next_cycle();
        end

        // Response buses are broadcast from the slave.
        s_rresp = 2'b10;
        s_bresp = 2'b00;
        #1;
        check("broadcast", 128'({rr_m_rdata, rr_m_rresp, rr_m_bresp}), 128'({32'hDEAD_BEEF, 2'b10, 2'b00}));
        s_rresp = '0;

        // All three masters read continuously: grant cycles 0,1,2 with one idle cycle between.
        reset_dut();
        apply(vi(3'b111, 0, 0, 3'b111, 0, 5'b11000));
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            exp_rr = (k % 3 == 0) ? 3'b000 : 3'(1 << ((k / 3) % 3));
            exp_fp = (k % 3 == 0) ? 3'b000 : 3'b001;
            check($sformatf("fair%0d_rr", k), 128'({rr_grant, rr_busy}), 128'({exp_rr, |exp_rr}));
            check($sformatf("fair%0d_fp", k), 128'({fp_grant, fp_busy}), 128'({exp_fp, |exp_fp}));
            next_cycle();
        end

        // Masters 0 and 2 request; master 0 withdraws after three of its transactions.
        reset_dut();
        apply(vi(3'b101, 0, 0, 3'b111, 0, 5'b11000));
        for (int k = 0; k < 12; k++) begin
            if (k == 9) m_arvalid = 3'b100;
            @(negedge clk);
            if (k < 9) begin
                exp_fp = (k % 3 == 0) ? 3'b000 : 3'b001;
                exp_rr = (k % 3 == 0) ? 3'b000 : (((k / 3) % 2 == 0) ? 3'b001 : 3'b100);
            end else begin
                exp_fp = (k == 9) ? 3'b000 : 3'b100;
                exp_rr = exp_fp;
            end
            check($sformatf("prio%0d_rr", k), 128'({rr_grant, rr_busy}), 128'({exp_rr, |exp_rr}));
            check($sformatf("prio%0d_fp", k), 128'({fp_grant, fp_busy}), 128'({exp_fp, |exp_fp}));
            next_cycle();
        end

        // Reset while master 1 waits in RD_DATA, after master 0 moved the pointer to 1.
        reset_dut();
        apply(vi(3'b001, 0, 0, 3'b111, 0, 5'b11000));
        next_cycle();
        next_cycle();
        m_arvalid = 3'b010;
        next_cycle();
        next_cycle();
        s_rvalid = 1'b0;
        next_cycle();
        rst       = 1'b1;
        m_arvalid = 3'b011;
        @(negedge clk);
        check("midrst_pre_rr", 128'({rr_grant, rr_busy}), 128'({3'b010, 1'b1}));
        check("midrst_pre_fp", 128'({fp_grant, fp_busy}), 128'({3'b010, 1'b1}));
        next_cycle();
        rst      = 1'b0;
        s_rvalid = 1'b1;
        @(negedge clk);
        check("midrst_clear_rr", 128'(rr_out()), 128'(idle_o));
        check("midrst_clear_fp", 128'(fp_out()), 128'(idle_o));
        next_cycle();
        @(negedge clk);
        check("midrst_after_rr", 128'({rr_grant, rr_busy}), 128'({3'b001, 1'b1}));
        check("midrst_after_fp", 128'({fp_grant, fp_busy}), 128'({3'b001, 1'b1}));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
